// File: rtl/rr_arb8_32_pkg.sv
// rtl/rr_arb8_32_pkg.sv - shared types, sizes and one-hot decode for rr_arb8_32
// Purpose: FSM state encoding, requester count / select width, 3-to-8 one-hot decode.
// Ports: none (package).
package rr_arb8_32_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_32.sv
// rtl/mux8_32.sv - 8:1 multiplexer of 32-bit words with 3-bit select
// Purpose: datapath word select.
// Ports:
//   i_sel [2:0]        select
//   i_d0..i_d7 [31:0]  input words
//   o_data [31:0]      selected word
module mux8_32 (
  input  logic [2:0]  i_sel,
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  input  logic [31:0] i_d2,
  input  logic [31:0] i_d3,
  input  logic [31:0] i_d4,
  input  logic [31:0] i_d5,
  input  logic [31:0] i_d6,
  input  logic [31:0] i_d7,
  output logic [31:0] o_data
);

  always_comb begin
    case (i_sel)
      3'd0:    o_data = i_d0;
      3'd1:    o_data = i_d1;
      3'd2:    o_data = i_d2;
      3'd3:    o_data = i_d3;
      3'd4:    o_data = i_d4;
      3'd5:    o_data = i_d5;
      3'd6:    o_data = i_d6;
      default: o_data = i_d7;
    endcase
  end

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin winner pick for 8 requesters
// Purpose: first set request scanning ptr, ptr+1, ... wrapping 7->0.
// Ports:
//   i_req    [7:0]  request vector
//   i_ptr    [2:0]  highest-priority index
//   o_winner [2:0]  selected index (0 when no request)
//   o_any           any request present
module rr_pick8
  import rr_arb8_32_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);

  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_win;

  // Offsets are visited from the lowest priority back to the highest, so the
  // last hit (the closest index at or after ptr) is what remains in w_win.
  // The 3-bit add wraps modulo 8, which undoes the rotation.
  always_comb begin
    w_idx = '0;
    w_win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = i_ptr + SEL_W'(k);
      if (i_req[w_idx]) begin
        w_win = w_idx;
      end
    end
  end

  assign o_winner = w_win;
  assign o_any    = |i_req;

endmodule

// File: rtl/rr_arb8_32.sv
// rtl/rr_arb8_32.sv - round-robin arbiter, 8 requesters onto one 32-bit valid/ready sink
// Purpose: picks a winner, selects its word through mux8_32, handshakes downstream
//          and returns a one-hot ack to the winner.
// Optional feature macro: ARB_LOCK_EN (burst lock input and lock counter).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req [7:0]            per-requester request
//   d0..d7 [31:0]        per-requester data words
//   lock [7:0]           per-requester burst lock (ARB_LOCK_EN only)
//   out_valid            out_data valid
//   out_ready            sink accepts
//   out_data [31:0]      granted word
//   out_sel [2:0]        granted index (registered)
//   grant [7:0]          one-hot of out_sel while granting
//   ack [7:0]            one-hot handshake return to the winner
module rr_arb8_32
  import rr_arb8_32_pkg::*;
#(
  parameter int RESET_PTR = 0
`ifdef ARB_LOCK_EN
  , parameter int MAX_LOCK = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [31:0]       d0,
  input  logic [31:0]       d1,
  input  logic [31:0]       d2,
  input  logic [31:0]       d3,
  input  logic [31:0]       d4,
  input  logic [31:0]       d5,
  input  logic [31:0]       d6,
  input  logic [31:0]       d7,
`ifdef ARB_LOCK_EN
  input  logic [N_REQ-1:0]  lock,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  ack
);

  state_t           r_state;
  state_t           w_nxt_state;
  logic [SEL_W-1:0] r_out_sel;
  logic [SEL_W-1:0] w_nxt_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_nxt_ptr;
  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_valid;
  logic             w_hs;
`ifdef ARB_LOCK_EN
  logic [3:0]       r_lock_cnt;
  logic [3:0]       w_nxt_lock_cnt;
`endif

  rr_pick8 u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  mux8_32 u_mux (
    .i_sel  (r_out_sel),
    .i_d0   (d0),
    .i_d1   (d1),
    .i_d2   (d2),
    .i_d3   (d3),
    .i_d4   (d4),
    .i_d5   (d5),
    .i_d6   (d6),
    .i_d7   (d7),
    .o_data (out_data)
  );

  // Outputs are decoded from the registered state so an asynchronous reset
  // clears valid/grant/ack at once, without waiting for a clock edge.
  assign w_valid   = (r_state == ST_GRANT) && req[r_out_sel];
  assign w_hs      = w_valid && out_ready;
  assign out_valid = w_valid;
  assign out_sel   = r_out_sel;
  assign grant     = (r_state == ST_GRANT) ? onehot8(r_out_sel) : '0;
  assign ack       = w_hs ? onehot8(r_out_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_out_sel  <= '0;
      r_ptr      <= SEL_W'(RESET_PTR);
`ifdef ARB_LOCK_EN
      r_lock_cnt <= '0;
`endif
    end else begin
      r_state    <= w_nxt_state;
      r_out_sel  <= w_nxt_sel;
      r_ptr      <= w_nxt_ptr;
`ifdef ARB_LOCK_EN
      r_lock_cnt <= w_nxt_lock_cnt;
`endif
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_out_sel;
    w_nxt_ptr   = r_ptr;
`ifdef ARB_LOCK_EN
    w_nxt_lock_cnt = r_lock_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_nxt_sel   = w_winner;
          w_nxt_state = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[r_out_sel]) begin
          // Withdrawal: give up the slot without moving priority.
          w_nxt_state = ST_IDLE;
`ifdef ARB_LOCK_EN
          w_nxt_lock_cnt = '0;
`endif
        end else if (w_hs) begin
`ifdef ARB_LOCK_EN
          if (lock[r_out_sel] && (r_lock_cnt < 4'(MAX_LOCK - 1))) begin
            // Locked burst: keep the grant, no IDLE bubble.
            w_nxt_lock_cnt = r_lock_cnt + 4'd1;
          end else begin
            w_nxt_lock_cnt = '0;
            w_nxt_ptr      = r_out_sel + SEL_W'(1);
            w_nxt_state    = ST_IDLE;
          end
`else
          w_nxt_ptr   = r_out_sel + SEL_W'(1);
          w_nxt_state = ST_IDLE;
`endif
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

endmodule

// File: doc/rr_arb8_32.md
Name: rr_arb8_32

Overview:
- Round-robin arbiter sharing one 32-bit sink between 8 requesters.
- Each requester presents a request and a 32-bit word.
- The block picks a winner and drives the select of a 3-bit-select 8:1 32-bit mux instance.
- It presents a valid/ready handshake downstream and returns a one-hot ack to the winning requester. Used for shared register-file write-back and shared memory port sourcing.

Parameters:
- RESET_PTR, 0, requester index with highest priority after reset (0..7).
- MAX_LOCK, 4, max consecutive transfers a locked requester may hold the grant (only with ARB_LOCK_EN; 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request per requester; bit i = requester i.
- d0..d7  in  32 each  data word of requester i; must be held stable while req[i]=1 and ack[i]=0.
- lock  in  8  burst-lock per requester (present only with ARB_LOCK_EN).
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts this cycle.
- out_data  out  32  word of the granted requester (mux output).
- out_sel  out  3  granted index (registered).
- grant  out  8  one-hot of out_sel while state=GRANT, else 0.
- ack  out  8  one-hot, combinational; ack[out_sel]=out_valid&out_ready.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_sel=0, ptr=RESET_PTR, lock_cnt=0.
  - Hence out_valid=0, grant=0, ack=0; out_data = d0 (mux follows out_sel).
- States: IDLE, GRANT.
- ptr = highest-priority index. Winner = first i with req[i]=1 scanning ptr, ptr+1, … mod 8 (wrap 7->0).
- IDLE:
  - If req!=0: out_sel<=winner, state<=GRANT.
  - Else stay in IDLE.
  - Latency: req edge to out_valid = 1 cycle.
- GRANT:
  - out_valid = req[out_sel]; out_data = d[out_sel] via the mux instance.
  - Handshake (out_valid&out_ready): ack[out_sel]=1 same cycle; ptr<=out_sel+1 mod 8; state<=IDLE.
  - Throughput: 1 transfer per 2 cycles per arbitration (mandatory IDLE bubble so a requester can drop or refresh req after ack).
  - Withdrawal (req[out_sel]=0 while in GRANT): out_valid=0, no ack, state<=IDLE, ptr unchanged.
  - out_ready=0 with valid: hold state, out_sel and out_data unchanged indefinitely. A newly asserted higher-priority req does not preempt.
- Requester keeping req high after ack means a new word. It competes in the next IDLE cycle at lowest priority (ptr moved past it).
- Simultaneous requests: exactly one grant; the others keep waiting. Starvation bound is 7 transfers.
- out_ready while out_valid=0: ignored.
- Reset mid-GRANT: transfer abandoned, no ack, all outputs return to reset values immediately.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - lock port present; 4-bit lock_cnt.
  - On handshake with lock[out_sel]=1, req[out_sel]=1 and lock_cnt<MAX_LOCK-1: stay in GRANT with same out_sel, lock_cnt++, ptr unchanged. Back-to-back transfers, no bubble.
  - Otherwise normal release: lock_cnt<=0, ptr advance.
  - lock_cnt also clears on withdrawal.
- Undefined: no lock port or counter; every handshake releases.

Decomposition:
- Shared package/header:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - N_REQ=8, SEL_W=3.
  - Shared 3-to-8 one-hot decode function (used for grant/ack).
- One sub-module, rr_pick8: combinational (req[7:0], ptr[2:0]) -> (winner[2:0], any). Isolates the rotate/priority-encode/unrotate logic for unit test.
- Datapath: the existing 8:1 32-bit mux instantiated, select=out_sel.

Test Plan:
- Single requester: req=8'h04, d2=32'hDEADBEEF, out_ready=1. Expected: out_valid high 1 cycle after req, out_data=32'hDEADBEEF, out_sel=2, ack=8'h04 that cycle, ptr=3 after.
- Fairness: req=8'hFF held, out_ready=1, reset ptr=0. Expected: grant order 0,1,…,7,0; one ack every 2 cycles; each ack one-hot.
- Backpressure: req=8'h81, out_ready=0 for 5 cycles then 1. Expected: out_sel=0 and out_data stable all 5 cycles; ack=8'h01 only on cycle 6; next grant=7.
- Withdrawal: grant requester 5, drop req[5] while out_ready=0. Expected: out_valid=0 same cycle, no ack, IDLE next cycle, ptr unchanged (5 still wins if re-requested first).
- Reset mid-GRANT: rst_n low asynchronously while out_valid=1. Expected: out_valid, grant and ack = 0 without clock edge; after release first winner scans from RESET_PTR.
- ARB_LOCK_EN: MAX_LOCK=4, req=8'h03, lock=8'h01, out_ready=1. Expected: 4 back-to-back acks to 0 with no bubble, then release; next grant=1.
